// File: rtl/pong_pkg.sv
// Shared screen timing, object geometry and colour codes for the pong game core and renderer.
package pong_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned BALL_SIZE     = 10;
    localparam int unsigned PADDLE_WIDTH  = 10;
    localparam int unsigned PADDLE_HEIGHT = 60;
    localparam int unsigned OPP_X         = 630;

    localparam int unsigned NET_X_LO = 318;
    localparam int unsigned NET_X_HI = 321;

    localparam int unsigned BALL_X_RESET   = 320;
    localparam int unsigned BALL_Y_RESET   = 240;
    localparam int unsigned PADDLE_Y_RESET = 210;

    localparam logic [5:0] COL_WHITE = 6'b111111;
    localparam logic [5:0] COL_NET   = 6'b010101;
    localparam logic [5:0] COL_BLACK = 6'b000000;

    // lo <= pos < lo + size, widened to 11 bits so lo + size cannot wrap.
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] lo,
                                     input logic [9:0] size);
        return (pos >= lo) && ({1'b0, pos} < ({1'b0, lo} + {1'b0, size}));
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA pixel/line counters with raw (unregistered) sync, blanking and per-frame snapshot strobe.
module vga_timing_gen
    import pong_pkg::*;
#(
    parameter int unsigned HActive = pong_pkg::H_ACTIVE,
    parameter int unsigned HFp     = pong_pkg::H_FP,
    parameter int unsigned HSync   = pong_pkg::H_SYNC,
    parameter int unsigned HBp     = pong_pkg::H_BP,
    parameter int unsigned VActive = pong_pkg::V_ACTIVE,
    parameter int unsigned VFp     = pong_pkg::V_FP,
    parameter int unsigned VSync   = pong_pkg::V_SYNC,
    parameter int unsigned VBp     = pong_pkg::V_BP
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de_o,
    output logic       snapshot_o
);

    localparam logic [9:0] HLast    = 10'(HActive + HFp + HSync + HBp - 1);
    localparam logic [9:0] VLast    = 10'(VActive + VFp + VSync + VBp - 1);
    localparam logic [9:0] HVis     = 10'(HActive);
    localparam logic [9:0] VVis     = 10'(VActive);
    localparam logic [9:0] HSyncLo  = 10'(HActive + HFp);
    localparam logic [9:0] HSyncEnd = 10'(HActive + HFp + HSync);
    localparam logic [9:0] VSyncLo  = 10'(VActive + VFp);
    localparam logic [9:0] VSyncEnd = 10'(VActive + VFp + VSync);
    localparam logic [9:0] VSnap    = 10'(VActive - 1);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o    = h_q;
    assign v_cnt_o    = v_q;
    assign hsync_o    = !((h_q >= HSyncLo) && (h_q < HSyncEnd));
    assign vsync_o    = !((v_q >= VSyncLo) && (v_q < VSyncEnd));
    assign de_o       = (h_q < HVis) && (v_q < VVis);
    // Last pixel of the last visible line: latch coordinates for the next frame.
    assign snapshot_o = (h_q == HLast) && (v_q == VSnap);

endmodule

// File: rtl/pong_vga_renderer.sv
// Pong renderer: per-frame coordinate snapshot, object hit tests and registered VGA outputs.
module pong_vga_renderer
    import pong_pkg::*;
#(
    parameter int unsigned HActive = pong_pkg::H_ACTIVE,
    parameter int unsigned HFp     = pong_pkg::H_FP,
    parameter int unsigned HSync   = pong_pkg::H_SYNC,
    parameter int unsigned HBp     = pong_pkg::H_BP,
    parameter int unsigned VActive = pong_pkg::V_ACTIVE,
    parameter int unsigned VFp     = pong_pkg::V_FP,
    parameter int unsigned VSync   = pong_pkg::V_SYNC,
    parameter int unsigned VBp     = pong_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_y,
    input  logic [9:0] opp_paddle_y,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [5:0] rgb,
    output logic       frame_tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt
);

    logic hsync_raw, vsync_raw, de_raw, snapshot;

    vga_timing_gen #(
        .HActive (HActive),
        .HFp     (HFp),
        .HSync   (HSync),
        .HBp     (HBp),
        .VActive (VActive),
        .VFp     (VFp),
        .VSync   (VSync),
        .VBp     (VBp)
    ) u_timing (
        .clk_i      (clk),
        .rst_i      (rst),
        .h_cnt_o    (h_cnt),
        .v_cnt_o    (v_cnt),
        .hsync_o    (hsync_raw),
        .vsync_o    (vsync_raw),
        .de_o       (de_raw),
        .snapshot_o (snapshot)
    );

    logic [9:0] ball_x_q, ball_y_q, paddle_y_q, opp_y_q;
    logic       hsync_q, vsync_q, de_q, frame_tick_q;
    logic [5:0] rgb_q, rgb_d;
    logic       hit_ball, hit_paddle, hit_net;

    always_comb begin
        hit_ball   = in_span(h_cnt, ball_x_q, 10'(BALL_SIZE))
                  && in_span(v_cnt, ball_y_q, 10'(BALL_SIZE));
        hit_paddle = ((h_cnt < 10'(PADDLE_WIDTH))
                      && in_span(v_cnt, paddle_y_q, 10'(PADDLE_HEIGHT)))
                  || (in_span(h_cnt, 10'(OPP_X), 10'(PADDLE_WIDTH))
                      && in_span(v_cnt, opp_y_q, 10'(PADDLE_HEIGHT)));
        // Dashed centre line: 16 lines drawn, 16 lines skipped.
        hit_net    = (h_cnt >= 10'(NET_X_LO)) && (h_cnt <= 10'(NET_X_HI)) && !v_cnt[4];

        rgb_d = COL_BLACK;
        if (de_raw) begin
            if (hit_ball) begin
                rgb_d = COL_WHITE;
            end else if (hit_paddle) begin
                rgb_d = COL_WHITE;
            end else if (hit_net) begin
                rgb_d = COL_NET;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ball_x_q     <= 10'(BALL_X_RESET);
            ball_y_q     <= 10'(BALL_Y_RESET);
            paddle_y_q   <= 10'(PADDLE_Y_RESET);
            opp_y_q      <= 10'(PADDLE_Y_RESET);
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            de_q         <= 1'b0;
            rgb_q        <= COL_BLACK;
            frame_tick_q <= 1'b0;
        end else begin
            if (snapshot) begin
                ball_x_q   <= ball_x;
                ball_y_q   <= ball_y;
                paddle_y_q <= paddle_y;
                opp_y_q    <= opp_paddle_y;
            end
            hsync_q      <= hsync_raw;
            vsync_q      <= vsync_raw;
            de_q         <= de_raw;
            rgb_q        <= rgb_d;
            frame_tick_q <= snapshot;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign de         = de_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Scoreboard bench for pong_vga_renderer: reference model predicts every output cycle.
module tb_pong_vga_renderer;

    // Vertical geometry is shrunk so several full frames fit in a short run.
    localparam int VA    = 20;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int VT    = VA + VF + VS + VB;
    localparam int HT    = 800;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] ball_x, ball_y, paddle_y, opp_paddle_y;
    logic       hsync, vsync, de, frame_tick;
    logic [5:0] rgb;
    logic [9:0] h_cnt, v_cnt;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic [5:0] rgb;
        logic       ft;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pong_vga_renderer #(
        .VActive (VA),
        .VFp     (VF),
        .VSync   (VS),
        .VBp     (VB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .paddle_y     (paddle_y),
        .opp_paddle_y (opp_paddle_y),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .rgb          (rgb),
        .frame_tick   (frame_tick),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [5:0] ref_pixel(input int h, input int v, input int bx, input int by,
                                             input int py, input int op);
        if (h >= bx && h < bx + 10 && v >= by && v < by + 10) return 6'b111111;
        if (h < 10 && v >= py && v < py + 60) return 6'b111111;
        if (h >= 630 && h < 640 && v >= op && v < op + 60) return 6'b111111;
        if (h >= 318 && h <= 321 && (v / 16) % 2 == 0) return 6'b010101;
        return 6'b000000;
    endfunction

    // Reference model: screen position is a pure function of cycles since reset.
    int unsigned t;
    bit          started = 1'b0;
    int          sbx, sby, spy, sop;

    always @(posedge clk) begin : model
        obs_t e;
        int   h, v, nt;
        if (rst) begin
            started = 1'b1;
            t   = 0;
            sbx = 320;
            sby = 240;
            spy = 210;
            sop = 210;
            e   = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 6'd0, ft: 1'b0};
            exp_q.push_back(e);
        end else if (started) begin
            h  = int'(t % HT);
            v  = int'((t / HT) % VT);
            nt = int'(t) + 1;
            e.h   = 10'(nt % HT);
            e.v   = 10'((nt / HT) % VT);
            e.hs  = (h >= 656 && h < 752) ? 1'b0 : 1'b1;
            e.vs  = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
            e.de  = (h < 640 && v < VA);
            e.rgb = e.de ? ref_pixel(h, v, sbx, sby, spy, sop) : 6'd0;
            e.ft  = (h == HT - 1 && v == VA - 1);
            if (e.ft) begin
                sbx = 32'(ball_x);
                sby = 32'(ball_y);
                spy = 32'(paddle_y);
                sop = 32'(opp_paddle_y);
            end
            t = 32'(nt);
            exp_q.push_back(e);
        end
    end

    int   ncyc    = 0;
    int   last_ft = -1;
    int   hs_run  = 0;
    int   vs_run  = 0;
    logic hs_prev = 1'b1;

    always @(negedge clk) begin : monitor
        obs_t a, e;
        ncyc++;
        a = '{h: h_cnt, v: v_cnt, hs: hsync, vs: vsync, de: de, rgb: rgb, ft: frame_tick};
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL stream cyc=%0d got h=%0d v=%0d hs=%b vs=%b de=%b rgb=%b ft=%b required h=%0d v=%0d hs=%b vs=%b de=%b rgb=%b ft=%b",
                         ncyc, a.h, a.v, a.hs, a.vs, a.de, a.rgb, a.ft,
                         e.h, e.v, e.hs, e.vs, e.de, e.rgb, e.ft);
            end
        end
        if (!hsync && hs_prev) check("hsync_start_h", 32'(h_cnt), 657);
        if (!hsync) hs_run++;
        else if (hs_run != 0) begin
            check("hsync_width", hs_run, 96);
            hs_run = 0;
        end
        hs_prev = hsync;
        if (!vsync) vs_run++;
        else if (vs_run != 0) begin
            check("vsync_width", vs_run, 1600);
            vs_run = 0;
        end
        if (frame_tick) begin
            if (last_ft >= 0) check("frame_tick_period", ncyc - last_ft, FRAME);
            last_ft = ncyc;
        end
    end

    logic [9:0] plan_bx[4], plan_by[4], plan_py[4], plan_op[4];

    task automatic churn();
        ball_x       = 10'($urandom_range(0, 1023));
        ball_y       = 10'($urandom_range(0, 1023));
        paddle_y     = 10'($urandom_range(0, 1023));
        opp_paddle_y = 10'($urandom_range(0, 1023));
    endtask

    initial begin : stim
        // Coordinates captured at each frame's snapshot line.
        plan_bx[0] = 10'd100; plan_by[0] = 10'd5;  plan_py[0] = 10'd0;  plan_op[0] = 10'd8;
        plan_bx[1] = 10'd635; plan_by[1] = 10'd15; plan_py[1] = 10'd15; plan_op[1] = 10'd1020;
        plan_bx[2] = 10'd315; plan_by[2] = 10'd0;
        plan_py[2] = 10'($urandom_range(0, 30));
        plan_op[2] = 10'($urandom_range(0, 30));
        plan_bx[3] = 10'($urandom_range(0, 700));
        plan_by[3] = 10'($urandom_range(0, 25));
        plan_py[3] = 10'($urandom_range(0, 25));
        plan_op[3] = 10'($urandom_range(0, 25));

        rst = 1'b1;
        churn();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4 * FRAME + 5 * HT + 300; i++) begin
            int v, f;
            v = (i / HT) % VT;
            f = i / FRAME;
            if (v == VA - 1 && f < 4) begin
                ball_x       = plan_bx[f];
                ball_y       = plan_by[f];
                paddle_y     = plan_py[f];
                opp_paddle_y = plan_op[f];
            end else if ($urandom_range(0, 49) == 0) begin
                churn();
            end
            @(negedge clk);
        end
        // Mid-frame reset: counters and shadows must restart cleanly.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) churn();
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_vga_renderer.md
Name: pong_vga_renderer

Overview:
Consumer end of the pong position interface. Takes ball and paddle coordinates from the game core and produces 640x480@60 VGA timing plus 2-bit-per-channel RGB for the TinyTapeout VGA PMOD. Coordinates are snapshotted once per frame so the picture never tears mid-frame. Sits between the game core and the uo_out pin mapping.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch (line total 800)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse lines
V_BP, 33, vertical back porch (frame total 525)
BALL_SIZE, 10, ball edge length in pixels
PADDLE_WIDTH, 10, paddle width
PADDLE_HEIGHT, 60, paddle height
OPP_X, 630, left x of opponent paddle

Ports:
clk  in  1  pixel clock, one pixel per cycle
rst  in  1  synchronous, active-high reset
ball_x  in  10  ball left edge
ball_y  in  10  ball top edge
paddle_y  in  10  player paddle top edge, x fixed at 0
opp_paddle_y  in  10  opponent paddle top edge, x fixed at OPP_X
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
de  out  1  high during the visible area
rgb  out  6  {r[1:0],g[1:0],b[1:0]}
frame_tick  out  1  one-cycle pulse per frame, aligned with the snapshot
h_cnt  out  10  current pixel column counter (unregistered)
v_cnt  out  10  current line counter (unregistered)

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; port names are clk and rst.
- Reset values: h_cnt=0, v_cnt=0, hsync=1, vsync=1, de=0, rgb=0, frame_tick=0. Shadow registers load ball=(320,240), paddle_y=210, opp_paddle_y=210.
- Counters:
  - h_cnt counts 0..799 and wraps to 0.
  - v_cnt increments when h_cnt=799 and wraps 524 -> 0.
  - Reset asserted mid-frame returns both counters to 0 on the next edge.
- Output latency: all outputs except h_cnt and v_cnt are registered, exactly 1 cycle after the counter value they describe.
- Sync and blanking:
  - hsync is low for h in 656..751.
  - vsync is low for v in 490..491.
  - de is high for h<640 and v<480.
- Snapshot:
  - On the cycle with h=799 and v=479, all four inputs are copied into shadow registers.
  - frame_tick is registered high for that cycle's output slot only.
  - Input changes at any other time have no effect until the next snapshot.
- Hit tests: on shadow values, computed with 11-bit arithmetic so that pos+size never wraps.
  - ball: ball_x <= h < ball_x+BALL_SIZE and ball_y <= v < ball_y+BALL_SIZE.
  - player paddle: h < PADDLE_WIDTH and paddle_y <= v < paddle_y+PADDLE_HEIGHT.
  - opponent paddle: OPP_X <= h < OPP_X+PADDLE_WIDTH and opp_paddle_y <= v < opp_paddle_y+PADDLE_HEIGHT.
  - net: 318 <= h <= 321 and v[4]==0 (dashed, 16-line segments).
- Colour priority: ball (6'b111111) > paddles (6'b111111) > net (6'b010101) > background (0).
- Blanking: rgb is forced to 0 whenever de would be 0.
- Clipping: objects partially off-screen are clipped at x=639 / y=479. They do not wrap onto the next line or frame. Coordinates >= 640/480 draw nothing.

Decomposition:
- Shared package pong_pkg holds:
  - screen and timing constants (the parameters above, plus H_TOTAL=800 and V_TOTAL=525);
  - colour codes COL_WHITE, COL_NET, COL_BLACK;
  - object sizes, so the game core and this renderer share one source.
- One sub-module, vga_timing_gen, contains:
  - the h/v counters;
  - raw hsync/vsync/de;
  - the snapshot strobe.
- The renderer adds the shadow registers, hit tests and output register stage.

Test Plan:
- Hold rst for 3 cycles, then release -> during reset hsync=1, vsync=1, de=0, rgb=0. First post-reset cycle has h_cnt=0, v_cnt=0; registered de=1 one cycle later.
- Free-run 2 frames -> hsync low exactly 96 cycles per 800-cycle line, starting 657 cycles after line start. vsync low for exactly 1600 cycles. frame_tick period is 420000 cycles.
- ball_x=100, ball_y=50 applied before a snapshot -> next frame pixels (100,50) and (109,59) are 6'b111111; pixels (99,50), (110,50) and (100,60) are 0.
- Change ball_x from 100 to 300 at v=200 -> rest of the current frame still draws at x=100. Frame after the following frame_tick draws at x=300.
- paddle_y=0, opp_paddle_y=420 -> x 0..9, y 0..59 white; x 630..639, y 420..479 white; (319,5) = 6'b010101; (319,20) = 0; (319,5) with ball at (315,0) = white (priority).
- ball_x=635, ball_y=475 -> only x 635..639, y 475..479 white. Pixels (0..4, 476) on the next line and row y=0 of the next frame stay 0. ball_y=1020 -> no ball pixels anywhere.
